// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared phase encoding and light decoding for the intersection sequencer
//
// Purpose : phase enum, light constants and the phase-to-lights mapping.
// Ports   : none (package).

package tl_pkg;

  typedef enum logic [2:0] {
    PH_NS_GREEN  = 3'd0,
    PH_NS_YELLOW = 3'd1,
    PH_ALLRED_A  = 3'd2,  // clearance after EW, precedes NS green
    PH_EW_GREEN  = 3'd3,
    PH_EW_YELLOW = 3'd4,
    PH_ALLRED_B  = 3'd5,  // clearance after NS, precedes EW green
    PH_FLASH     = 3'd6
  } phase_e;

  localparam logic [2:0] TL_RED = 3'b100;
  localparam logic [2:0] TL_YEL = 3'b010;
  localparam logic [2:0] TL_GRN = 3'b001;
  localparam logic [2:0] TL_OFF = 3'b000;

  // Returns {tl_3, tl_2, tl_1, tl_0}. Approaches 0/2 are NS, 1/3 are EW.
  function automatic logic [11:0] phase_lights(input phase_e ph, input logic blink);
    logic [2:0] ns;
    logic [2:0] ew;
    ns = TL_RED;
    ew = TL_RED;
    case (ph)
      PH_NS_GREEN:  ns = TL_GRN;
      PH_NS_YELLOW: ns = TL_YEL;
      PH_EW_GREEN:  ew = TL_GRN;
      PH_EW_YELLOW: ew = TL_YEL;
      PH_FLASH: begin
        ns = blink ? TL_YEL : TL_OFF;
        ew = blink ? TL_YEL : TL_OFF;
      end
      default: begin
        ns = TL_RED;
        ew = TL_RED;
      end
    endcase
    return {ew, ns, ew, ns};
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// rtl/tl_tick_gen.sv - one-second tick prescaler
//
// Purpose : counts 0..CLK_HZ-1 and pulses tick_o for one cycle while the count is CLK_HZ-1.
// Ports   : clk_i  - system clock
//           rst_i  - asynchronous active-high reset
//           tick_o - registered one-cycle pulse, once every CLK_HZ cycles

module tl_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // tick is registered from the next count so it coincides with count == LAST.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tl_phase_sequencer.sv
// rtl/tl_phase_sequencer.sv - six-phase traffic-light sequencer with demand rest and flash mode
//
// Purpose : steps the signal plan once per second tick, drives the four approach lights
//           and a BCD countdown of the seconds left in the current phase.
// Ports   : clk_clk     - system clock
//           reset_reset - asynchronous active-high reset (forces all-red immediately)
//           flash_mode  - maintenance request, level
//           req[3:0]    - per-approach vehicle demand, level
//           tl_0..tl_3  - lights {red, yellow, green} for approaches 0..3
//           phase       - current phase code
//           remain_bcd  - seconds remaining, two BCD digits
//           tick        - one-cycle pulse per second

module tl_phase_sequencer
  import tl_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int GREEN_S  = 20,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       flash_mode,
  input  logic [3:0] req,
  output logic [2:0] tl_0,
  output logic [2:0] tl_1,
  output logic [2:0] tl_2,
  output logic [2:0] tl_3,
  output logic [2:0] phase,
  output logic [7:0] remain_bcd,
  output logic       tick
);

  localparam logic [6:0] GREEN_D  = 7'(GREEN_S);
  localparam logic [6:0] YELLOW_D = 7'(YELLOW_S);
  localparam logic [6:0] ALLRED_D = 7'(ALLRED_S);

  // Repeated subtraction is enough for a 7-bit value; at most 12 tens fit.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rest;
    tens = 4'd0;
    rest = v;
    for (int i = 0; i < 12; i++) begin
      if (rest >= 7'd10) begin
        rest = rest - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rest[3:0]};
  endfunction

  logic       tick_w;
  phase_e     phase_q,  phase_d;
  logic [6:0] remain_q, remain_d;
  logic       blink_q,  blink_d;
  logic [11:0] lights_q;
  logic [7:0] bcd_q;
  logic       expire;
  logic       ns_cross;
  logic       ew_cross;

  tl_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk_i  (clk_clk),
    .rst_i  (reset_reset),
    .tick_o (tick_w)
  );

  assign ns_cross = req[1] | req[3];
  assign ew_cross = req[0] | req[2];
  // <= rather than == so a stray zero can never stall a timed phase.
  assign expire   = (remain_q <= 7'd1);

  always_comb begin
    phase_d  = phase_q;
    remain_d = remain_q;
    blink_d  = blink_q;
    if (tick_w) begin
      case (phase_q)
        PH_NS_GREEN: begin
          // Flash request cuts green short; otherwise rest in green until cross demand.
          if (flash_mode || (expire && ns_cross)) begin
            phase_d  = PH_NS_YELLOW;
            remain_d = YELLOW_D;
          end else if (expire) begin
            remain_d = GREEN_D;
          end else begin
            remain_d = remain_q - 7'd1;
          end
        end
        PH_NS_YELLOW: begin
          if (expire) begin
            phase_d  = PH_ALLRED_B;
            remain_d = ALLRED_D;
          end else begin
            remain_d = remain_q - 7'd1;
          end
        end
        PH_ALLRED_B: begin
          if (expire && flash_mode) begin
            phase_d  = PH_FLASH;
            remain_d = 7'd0;
            blink_d  = 1'b1;
          end else if (expire) begin
            phase_d  = PH_EW_GREEN;
            remain_d = GREEN_D;
          end else begin
            remain_d = remain_q - 7'd1;
          end
        end
        PH_EW_GREEN: begin
          if (flash_mode || (expire && ew_cross)) begin
            phase_d  = PH_EW_YELLOW;
            remain_d = YELLOW_D;
          end else if (expire) begin
            remain_d = GREEN_D;
          end else begin
            remain_d = remain_q - 7'd1;
          end
        end
        PH_EW_YELLOW: begin
          if (expire) begin
            phase_d  = PH_ALLRED_A;
            remain_d = ALLRED_D;
          end else begin
            remain_d = remain_q - 7'd1;
          end
        end
        PH_ALLRED_A: begin
          if (expire && flash_mode) begin
            phase_d  = PH_FLASH;
            remain_d = 7'd0;
            blink_d  = 1'b1;
          end else if (expire) begin
            phase_d  = PH_NS_GREEN;
            remain_d = GREEN_D;
          end else begin
            remain_d = remain_q - 7'd1;
          end
        end
        PH_FLASH: begin
          if (!flash_mode) begin
            phase_d  = PH_ALLRED_A;
            remain_d = ALLRED_D;
          end else begin
            blink_d  = ~blink_q;
          end
        end
        default: begin
          phase_d  = PH_ALLRED_A;
          remain_d = ALLRED_D;
        end
      endcase
    end
  end

  // Lights and BCD are registered from next-state so they change on the same edge as phase.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      phase_q  <= PH_ALLRED_A;
      remain_q <= ALLRED_D;
      blink_q  <= 1'b1;
      lights_q <= {TL_RED, TL_RED, TL_RED, TL_RED};
      bcd_q    <= bin2bcd(ALLRED_D);
    end else begin
      phase_q  <= phase_d;
      remain_q <= remain_d;
      blink_q  <= blink_d;
      lights_q <= phase_lights(phase_d, blink_d);
      bcd_q    <= bin2bcd(remain_d);
    end
  end

  assign tl_0       = lights_q[2:0];
  assign tl_1       = lights_q[5:3];
  assign tl_2       = lights_q[8:6];
  assign tl_3       = lights_q[11:9];
  assign phase      = phase_q;
  assign remain_bcd = bcd_q;
  assign tick       = tick_w;

endmodule

// File: tb/tb_tl_phase_sequencer.sv
// tb/tb_tl_phase_sequencer.sv - directed self-checking bench for tl_phase_sequencer

module tb_tl_phase_sequencer;

  localparam logic [2:0] P_NSG = 3'd0;
  localparam logic [2:0] P_NSY = 3'd1;
  localparam logic [2:0] P_ARA = 3'd2;
  localparam logic [2:0] P_EWG = 3'd3;
  localparam logic [2:0] P_EWY = 3'd4;
  localparam logic [2:0] P_ARB = 3'd5;
  localparam logic [2:0] P_FLS = 3'd6;

  // {tl_3, tl_2, tl_1, tl_0}
  localparam logic [11:0] L_NSG = 12'b100_001_100_001;
  localparam logic [11:0] L_NSY = 12'b100_010_100_010;
  localparam logic [11:0] L_EWG = 12'b001_100_001_100;
  localparam logic [11:0] L_EWY = 12'b010_100_010_100;
  localparam logic [11:0] L_RED = 12'b100_100_100_100;
  localparam logic [11:0] L_FON = 12'b010_010_010_010;
  localparam logic [11:0] L_FOF = 12'b000_000_000_000;

  logic       clk_clk;
  logic       reset_reset;
  logic       flash_mode;
  logic [3:0] req;
  logic [2:0] tl_0, tl_1, tl_2, tl_3;
  logic [2:0] phase;
  logic [7:0] remain_bcd;
  logic       tick;

  int checks;
  int failures;
  int tick_no;
  logic [2:0] prev_ph;

  tl_phase_sequencer #(
    .CLK_HZ   (4),
    .GREEN_S  (5),
    .YELLOW_S (2),
    .ALLRED_S (1)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .flash_mode  (flash_mode),
    .req         (req),
    .tl_0        (tl_0),
    .tl_1        (tl_1),
    .tl_2        (tl_2),
    .tl_3        (tl_3),
    .phase       (phase),
    .remain_bcd  (remain_bcd),
    .tick        (tick)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string pre, input logic [2:0] ph, input logic [11:0] lt,
                              input logic [7:0] bcd);
    chk({pre, "_phase"}, 32'(phase), 32'(ph));
    chk({pre, "_lights"}, 32'({tl_3, tl_2, tl_1, tl_0}), 32'(lt));
    chk({pre, "_bcd"}, 32'(remain_bcd), 32'(bcd));
  endtask

  // Waits (bounded) for the next tick, then samples the state it produced.
  task automatic tick_expect(input logic [2:0] ph, input logic [11:0] lt, input logic [7:0] bcd);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 8) begin
      @(negedge clk_clk);
      n++;
    end
    tick_no++;
    chk($sformatf("t%0d_gap", tick_no), 32'(n), 32'd3);
    @(negedge clk_clk);
    chk($sformatf("t%0d_pulse", tick_no), 32'(tick), 32'd0);
    expect_state($sformatf("t%0d", tick_no), ph, lt, bcd);
  endtask

  // Safety monitor: no conflicting movement, and green -> yellow -> all-red ordering.
  always @(negedge clk_clk) begin
    logic ns_nr;
    logic ew_nr;
    logic [2:0] nxt;
    logic has_rule;
    if (reset_reset) begin
      prev_ph <= P_ARA;
    end else begin
      ns_nr = (tl_0 != 3'b100) || (tl_2 != 3'b100);
      ew_nr = (tl_1 != 3'b100) || (tl_3 != 3'b100);
      if (phase != P_FLS) chk("conflict", 32'(ns_nr & ew_nr), 32'd0);
      has_rule = 1'b1;
      nxt = P_ARA;
      case (prev_ph)
        P_NSG:   nxt = P_NSY;
        P_NSY:   nxt = P_ARB;
        P_EWG:   nxt = P_EWY;
        P_EWY:   nxt = P_ARA;
        default: has_rule = 1'b0;
      endcase
      if (phase != prev_ph && has_rule) chk("seq_order", 32'(phase), 32'(nxt));
      prev_ph <= phase;
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    tick_no     = 0;
    prev_ph     = P_ARA;
    reset_reset = 1'b1;
    flash_mode  = 1'b0;
    req         = 4'b1111;
    repeat (2) @(negedge clk_clk);
    expect_state("rst", P_ARA, L_RED, 8'h01);
    chk("rst_tick", 32'(tick), 32'd0);
    #2 reset_reset = 1'b0;

    // Normal cycle with full demand
    tick_expect(P_NSG, L_NSG, 8'h05);
    for (int k = 4; k >= 1; k--) tick_expect(P_NSG, L_NSG, 8'(k));
    tick_expect(P_NSY, L_NSY, 8'h02);
    tick_expect(P_NSY, L_NSY, 8'h01);
    tick_expect(P_ARB, L_RED, 8'h01);
    tick_expect(P_EWG, L_EWG, 8'h05);
    tick_expect(P_EWG, L_EWG, 8'h04);

    // Flash request at EW green with 4 s left
    flash_mode = 1'b1;
    tick_expect(P_EWY, L_EWY, 8'h02);
    tick_expect(P_EWY, L_EWY, 8'h01);
    tick_expect(P_ARA, L_RED, 8'h01);
    tick_expect(P_FLS, L_FON, 8'h00);
    tick_expect(P_FLS, L_FOF, 8'h00);
    tick_expect(P_FLS, L_FON, 8'h00);
    flash_mode = 1'b0;
    tick_expect(P_ARA, L_RED, 8'h01);
    tick_expect(P_NSG, L_NSG, 8'h05);

    // NS demand only: green rests across three expiries
    req = 4'b0101;
    for (int e = 0; e < 3; e++) begin
      for (int k = 4; k >= 1; k--) tick_expect(P_NSG, L_NSG, 8'(k));
      tick_expect(P_NSG, L_NSG, 8'h05);
    end
    req = 4'b1101;
    for (int k = 4; k >= 1; k--) tick_expect(P_NSG, L_NSG, 8'(k));
    tick_expect(P_NSY, L_NSY, 8'h02);
    tick_expect(P_NSY, L_NSY, 8'h01);
    tick_expect(P_ARB, L_RED, 8'h01);
    tick_expect(P_EWG, L_EWG, 8'h05);
    for (int k = 4; k >= 1; k--) tick_expect(P_EWG, L_EWG, 8'(k));
    tick_expect(P_EWY, L_EWY, 8'h02);
    tick_expect(P_EWY, L_EWY, 8'h01);
    tick_expect(P_ARA, L_RED, 8'h01);
    tick_expect(P_NSG, L_NSG, 8'h05);
    tick_expect(P_NSG, L_NSG, 8'h04);

    // Asynchronous reset between clock edges during NS green
    @(posedge clk_clk);
    #2 reset_reset = 1'b1;
    #1 expect_state("async_rst", P_ARA, L_RED, 8'h01);
    @(negedge clk_clk);
    #2 reset_reset = 1'b0;
    #1 expect_state("post_rst", P_ARA, L_RED, 8'h01);
    tick_expect(P_NSG, L_NSG, 8'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
